hilo_muldiv_ctrl: RTL and testbench

Execute-stage HI/LO unit. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, drives the external multiplier and waits its fixed latency, and runs divides on an internal 32-iteration restoring divider. Owns the architectural HI/LO registers. Stalls the pipeline via `busy` while an operation is in flight. Sits between the execute-stage decode and the multiplier.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 28 ++
 rtl/hilo_muldiv_ctrl_if.sv | 29 ++
 rtl/hilo_muldiv_ctrl_div_iter.sv | 72 +++++++
 rtl/hilo_muldiv_ctrl.sv | 138 +++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - shared types and constants for the HI/LO multiply/divide unit
package hilo_muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV     = 2'd2,
    ST_DIV_FIX = 2'd3
  } muldiv_state_t;

  localparam int DIV_ITERS = 32;

  // Magnitude of a value, only when it is treated as signed and negative.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// rtl/hilo_muldiv_ctrl_if.sv - request, multiplier and HI/LO signals of the HI/LO unit
interface hilo_muldiv_ctrl_if;
  import hilo_muldiv_ctrl_pkg::*;

  logic        req_valid;
  muldiv_op_t  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_signed;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req_valid, req_op, src_a, src_b, flush, mul_hi, mul_lo,
    input  busy, mul_a, mul_b, mul_signed, hi, lo
  );

  modport slave (
    input  req_valid, req_op, src_a, src_b, flush, mul_hi, mul_lo,
    output busy, mul_a, mul_b, mul_signed, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// rtl/hilo_muldiv_ctrl_div_iter.sv - unsigned radix-2 restoring divider, one quotient bit per cycle
module hilo_muldiv_ctrl_div_iter
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  logic        r_run;
  logic        r_done;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvd;
  logic [31:0] r_dsr;
  logic [31:0] r_quo;
  logic [31:0] r_rem;

  // 33-bit partial remainder so divisors above 2^31 still compare correctly.
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;

  assign w_shift = {r_rem, r_dvd[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dsr});
  assign w_sub   = w_shift[31:0] - r_dsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dsr  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
    end else if (i_flush) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_dvd  <= i_dividend;
      r_dsr  <= i_divisor;
      r_quo  <= '0;
      r_rem  <= '0;
    end else if (r_run) begin
      r_rem <= w_ge ? w_sub : w_shift[31:0];
      r_quo <= {r_quo[30:0], w_ge};
      r_dvd <= {r_dvd[30:0], 1'b0};
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == LAST_ITER) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - execute-stage HI/LO unit: multiply sequencing, divide, HI/LO registers
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int MULT_LATENCY = 2
)
(
  input  logic               clk,
  input  logic               resetn,
  hilo_muldiv_ctrl_if.slave  bus
);

  localparam logic [4:0] MUL_LAST = 5'(MULT_LATENCY - 1);
  localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

  muldiv_state_t r_state;
  logic [4:0]    r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_mul_a;
  logic [31:0]   r_mul_b;
  logic          r_mul_signed;
  logic          r_div_signed;
  logic          r_dvd_neg;
  logic          r_dsr_neg;
  logic          r_dsr_zero;

  logic        w_accept;
  logic        w_is_div;
  logic        w_op_signed;
  logic        w_div_start;
  logic        w_div_done;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_accept    = bus.req_valid && !bus.flush && (r_state == ST_IDLE);
  assign w_is_div    = (bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU);
  assign w_op_signed = (bus.req_op == OP_DIV);
  assign w_div_start = w_accept && w_is_div;

  hilo_muldiv_ctrl_div_iter u_div_iter (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (w_div_start),
    .i_flush     (bus.flush),
    .i_dividend  (mag32(bus.src_a, w_op_signed)),
    .i_divisor   (mag32(bus.src_b, w_op_signed)),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // A zero divisor keeps the all-ones quotient; the remainder sign fix restores the raw dividend.
  assign w_quo_fix = (r_div_signed && (r_dvd_neg ^ r_dsr_neg) && !r_dsr_zero) ? (~w_quo + 32'd1) : w_quo;
  assign w_rem_fix = (r_div_signed && r_dvd_neg) ? (~w_rem + 32'd1) : w_rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_signed <= 1'b0;
      r_div_signed <= 1'b0;
      r_dvd_neg    <= 1'b0;
      r_dsr_neg    <= 1'b0;
      r_dsr_zero   <= 1'b0;
    end else if (bus.flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (bus.req_op)
              OP_MULT, OP_MULTU: begin
                r_mul_a      <= bus.src_a;
                r_mul_b      <= bus.src_b;
                r_mul_signed <= (bus.req_op == OP_MULT);
                r_cnt        <= '0;
                r_state      <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                r_div_signed <= w_op_signed;
                r_dvd_neg    <= w_op_signed && bus.src_a[31];
                r_dsr_neg    <= w_op_signed && bus.src_b[31];
                r_dsr_zero   <= (bus.src_b == 32'd0);
                r_cnt        <= '0;
                r_state      <= ST_DIV;
              end
              OP_MTHI: r_hi <= bus.src_a;
              OP_MTLO: r_lo <= bus.src_a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (r_cnt == MUL_LAST) begin
            r_hi    <= bus.mul_hi;
            r_lo    <= bus.mul_lo;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_DIV: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DIV_FIX;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_DIV_FIX: begin
          if (w_div_done) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.mul_signed = r_mul_signed;
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - self-checking bench for the HI/LO multiply/divide unit
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] prod;

  hilo_muldiv_ctrl_if bif();

  hilo_muldiv_ctrl #(.MULT_LATENCY(LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif.slave)
  );

  always #5 clk = ~clk;

  // External multiplier: one register stage, so the product is ready LAT=2 edges after the operands.
  always_comb begin
    if (bif.mul_signed)
      prod = 64'(64'($signed(bif.mul_a)) * 64'($signed(bif.mul_b)));
    else
      prod = {32'd0, bif.mul_a} * {32'd0, bif.mul_b};
  end
  always @(posedge clk) begin
    bif.mul_hi <= prod[63:32];
    bif.mul_lo <= prod[31:0];
  end

  function automatic logic [63:0] ref_result(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] hi, input logic [31:0] lo);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb, sq, sr;
    sa = a;
    sb = b;
    case (op)
      OP_MULT: begin
        sp = 64'(sa) * 64'(sb);
        return sp;
      end
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      OP_MTHI: return {a, lo};
      OP_MTLO: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int exp_cycles(input muldiv_op_t op);
    if (op == OP_MULT || op == OP_MULTU) return LAT;
    if (op == OP_DIV || op == OP_DIVU) return 33;
    return 0;
  endfunction

  task automatic do_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b, output int cyc);
    @(negedge clk);
    bif.req_valid = 1'b1;
    bif.req_op    = op;
    bif.src_a     = a;
    bif.src_b     = b;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    bif.req_op    = OP_NOP;
    cyc = 0;
    while (bif.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
    n_cmp++; if (bif.hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", bif.hi); end
    n_cmp++; if (bif.lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", bif.lo); end
    n_cmp++; if ({bif.mul_a, bif.mul_b} !== 64'd0) begin n_bad++; $display("FAIL reset_mul_ops: got %h/%h want 0", bif.mul_a, bif.mul_b); end
    n_cmp++; if (bif.mul_signed !== 1'b0) begin n_bad++; $display("FAIL reset_mul_signed: got %b want 0", bif.mul_signed); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mult;
    int cyc;
    do_op(OP_MULT, 32'hFFFFFFFD, 32'd5, cyc);
    n_cmp++; if (cyc != LAT) begin n_bad++; $display("FAIL mult_busy: got %0d want %0d", cyc, LAT); end
    n_cmp++; if (bif.hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", bif.hi); end
    n_cmp++; if (bif.lo !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL mult_lo: got %h want fffffff1", bif.lo); end
    n_cmp++; if (bif.mul_signed !== 1'b1) begin n_bad++; $display("FAIL mult_signed: got %b want 1", bif.mul_signed); end
  endtask

  task automatic test_multu_mtlo;
    int cyc;
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, cyc);
    n_cmp++; if (cyc != LAT) begin n_bad++; $display("FAIL multu_busy: got %0d want %0d", cyc, LAT); end
    n_cmp++; if ({bif.hi, bif.lo} !== 64'h00000001_FFFFFFFE) begin n_bad++; $display("FAIL multu_hilo: got %h_%h want 00000001_fffffffe", bif.hi, bif.lo); end
    do_op(OP_MTLO, 32'h55, 32'd0, cyc);
    n_cmp++; if (cyc != 0) begin n_bad++; $display("FAIL mtlo_busy: got %0d want 0", cyc); end
    n_cmp++; if (bif.lo !== 32'h55) begin n_bad++; $display("FAIL mtlo_lo: got %h want 00000055", bif.lo); end
    n_cmp++; if (bif.hi !== 32'h1) begin n_bad++; $display("FAIL mtlo_hi: got %h want 00000001", bif.hi); end
  endtask

  task automatic test_div;
    int cyc;
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL div_busy: got %0d want 33", cyc); end
    n_cmp++; if ({bif.hi, bif.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_bad++; $display("FAIL div_neg7_2: got %h_%h want ffffffff_fffffffd", bif.hi, bif.lo); end
    do_op(OP_DIVU, 32'd100, 32'd7, cyc);
    n_cmp++; if ({bif.hi, bif.lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL divu_100_7: got %h_%h want 00000002_0000000e", bif.hi, bif.lo); end
    do_op(OP_DIV, 32'h1234, 32'd0, cyc);
    n_cmp++; if ({bif.hi, bif.lo} !== 64'h00001234_FFFFFFFF) begin n_bad++; $display("FAIL div_by_zero: got %h_%h want 00001234_ffffffff", bif.hi, bif.lo); end
    do_op(OP_DIV, 32'hFFFFFF00, 32'd0, cyc);
    n_cmp++; if ({bif.hi, bif.lo} !== 64'hFFFFFF00_FFFFFFFF) begin n_bad++; $display("FAIL div_neg_by_zero: got %h_%h want ffffff00_ffffffff", bif.hi, bif.lo); end
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    n_cmp++; if ({bif.hi, bif.lo} !== 64'h00000000_80000000) begin n_bad++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", bif.hi, bif.lo); end
    do_op(OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, cyc);
    n_cmp++; if ({bif.hi, bif.lo} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL divu_large: got %h_%h want 00000001_00000001", bif.hi, bif.lo); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [63:0] e;
    e = ref_result(OP_DIVU, 32'd1000, 32'd33, 32'd0, 32'd0);
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_op = OP_DIVU; bif.src_a = 32'd1000; bif.src_b = 32'd33;
    @(posedge clk); #1;
    bif.req_op = OP_MTHI; bif.src_a = 32'hDEAD;
    cyc = 0;
    while (bif.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL b2b_busy: got %0d want 33", cyc); end
    n_cmp++; if ({bif.hi, bif.lo} !== e) begin n_bad++; $display("FAIL b2b_div_result: got %h_%h want %h", bif.hi, bif.lo, e); end
    @(posedge clk); #1;
    bif.req_valid = 1'b0; bif.req_op = OP_NOP;
    n_cmp++; if (bif.hi !== 32'hDEAD) begin n_bad++; $display("FAIL b2b_held_mthi: got %h want 0000dead", bif.hi); end
  endtask

  task automatic test_flush;
    int cyc;
    do_op(OP_MTHI, 32'hAA, 32'd0, cyc);
    do_op(OP_MTLO, 32'hBB, 32'd0, cyc);
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_op = OP_DIVU; bif.src_a = 32'd100; bif.src_b = 32'd7;
    @(posedge clk); #1;
    bif.req_valid = 1'b0; bif.req_op = OP_NOP;
    repeat (9) @(posedge clk);
    #1;
    n_cmp++; if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before: got %b want 1", bif.busy); end
    bif.flush = 1'b1;
    @(posedge clk); #1;
    bif.flush = 1'b0;
    n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_after: got %b want 0", bif.busy); end
    n_cmp++; if ({bif.hi, bif.lo} !== {32'hAA, 32'hBB}) begin n_bad++; $display("FAIL flush_hilo: got %h_%h want 000000aa_000000bb", bif.hi, bif.lo); end
    repeat (40) @(posedge clk);
    #1;
    n_cmp++; if ({bif.hi, bif.lo} !== {32'hAA, 32'hBB}) begin n_bad++; $display("FAIL flush_hilo_late: got %h_%h want 000000aa_000000bb", bif.hi, bif.lo); end
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_op = OP_MTHI; bif.src_a = 32'h77; bif.flush = 1'b1;
    @(posedge clk); #1;
    bif.req_valid = 1'b0; bif.req_op = OP_NOP; bif.flush = 1'b0;
    n_cmp++; if (bif.hi !== 32'hAA) begin n_bad++; $display("FAIL flush_drops_req: got %h want 000000aa", bif.hi); end
  endtask

  task automatic test_random;
    int cyc;
    muldiv_op_t op;
    logic [31:0] a, b;
    logic [63:0] e;
    muldiv_op_t ops[6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    logic [31:0] specials[4] = '{32'd0, 32'hFFFFFFFF, 32'h80000000, 32'd1};
    do_op(OP_MTHI, 32'd0, 32'd0, cyc);
    do_op(OP_MTLO, 32'd0, 32'd0, cyc);
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 31);
      e = ref_result(op, a, b, m_hi, m_lo);
      do_op(op, a, b, cyc);
      n_cmp++; if (cyc != exp_cycles(op)) begin n_bad++; $display("FAIL rand_busy[%0d] op=%0d: got %0d want %0d", i, op, cyc, exp_cycles(op)); end
      n_cmp++; if ({bif.hi, bif.lo} !== e) begin n_bad++; $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got %h_%h want %h", i, op, a, b, bif.hi, bif.lo, e); end
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  task automatic test_reset_mid_mul;
    int cyc;
    do_op(OP_MTHI, 32'h11, 32'd0, cyc);
    do_op(OP_MTLO, 32'h22, 32'd0, cyc);
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_op = OP_MULT; bif.src_a = 32'd7; bif.src_b = 32'd9;
    @(posedge clk); #1;
    bif.req_valid = 1'b0; bif.req_op = OP_NOP;
    n_cmp++; if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL rstmul_busy_before: got %b want 1", bif.busy); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL rstmul_busy: got %b want 0", bif.busy); end
    n_cmp++; if ({bif.hi, bif.lo} !== 64'd0) begin n_bad++; $display("FAIL rstmul_hilo: got %h_%h want 0", bif.hi, bif.lo); end
    n_cmp++; if ({bif.mul_signed, bif.mul_a, bif.mul_b} !== 65'd0) begin n_bad++; $display("FAIL rstmul_mul: got %b %h %h want 0", bif.mul_signed, bif.mul_a, bif.mul_b); end
    @(negedge clk);
    resetn = 1'b1;
    do_op(OP_MULTU, 32'd6, 32'd7, cyc);
    n_cmp++; if ({bif.hi, bif.lo} !== 64'd42) begin n_bad++; $display("FAIL rstmul_recover: got %h_%h want 0_2a", bif.hi, bif.lo); end
  endtask

  initial begin
    bif.req_valid = 1'b0;
    bif.req_op    = OP_NOP;
    bif.src_a     = 32'd0;
    bif.src_b     = 32'd0;
    bif.flush     = 1'b0;
    test_reset();
    test_mult();
    test_multu_mtlo();
    test_div();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
